// File: rtl/seq_alu.sv
// Multi-cycle unsigned ALU with valid/ready handshakes on both sides.
// Optional divider datapath enabled by defining SEQ_ALU_DIV_EN.
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 err
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_AND, OP_OR, OP_NOT, OP_XOR, OP_ADD, OP_SUB, OP_MUL, OP_DIV
  } op_t;

  state_t               state_q, state_d;
  op_t                  op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 err_q, err_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;

`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic                 div_ge;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    err_d    = err_q;
`ifdef SEQ_ALU_DIV_EN
    // acc holds {remainder, dividend/quotient}; shift one dividend bit into the remainder
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ge    = (div_shift >= {1'b0, b_q});
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          op_d     = op_t'(op);
          cnt_d    = '0;
          err_d    = 1'b0;
          result_d = '0;
          state_d  = S_DONE;
          unique case (op_t'(op))
            OP_AND: result_d[WIDTH-1:0] = a & b;
            OP_OR:  result_d[WIDTH-1:0] = a | b;
            OP_NOT: result_d[WIDTH-1:0] = ~a;
            OP_XOR: result_d[WIDTH-1:0] = a ^ b;
            OP_ADD: result_d[WIDTH:0]   = {1'b0, a} + {1'b0, b};
            OP_SUB: result_d[WIDTH:0]   = {1'b0, a} - {1'b0, b};
            OP_MUL: begin
              acc_d   = '0;
              state_d = S_BUSY;
            end
            OP_DIV: begin
`ifdef SEQ_ALU_DIV_EN
              if (b == '0) begin
                result_d = {a, {WIDTH{1'b1}}};
                err_d    = 1'b1;
              end else begin
                acc_d   = {{WIDTH{1'b0}}, a};
                state_d = S_BUSY;
              end
`else
              err_d = 1'b1;
`endif
            end
            default: ;
          endcase
        end
      end

      S_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        case (op_q)
          OP_MUL: begin
            if (b_q[cnt_q])
              acc_d = acc_q + ({{WIDTH{1'b0}}, a_q} << cnt_q);
          end
`ifdef SEQ_ALU_DIV_EN
          OP_DIV: begin
            acc_d = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};
          end
`endif
          default: ;
        endcase
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d  = S_DONE;
          result_d = acc_d;
        end
      end

      S_DONE: begin
        if (out_ready)
          state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_AND;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed test-plan cases plus random traffic
// against an arithmetic reference model, with random output backpressure.
module tb_seq_alu;

  localparam int unsigned W  = 8;
  localparam int unsigned RW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [2:0]    op = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [RW-1:0] result;
  logic          err;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [RW-1:0] res;
    logic          err;
    int            lat;
    int            acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;
  bit   outstanding = 1'b0;
  int   seen_cyc = -1;
  int   ready_mode = 0;  // 0 random, 1 held low, 2 held high

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model from the operation table, using plain integer arithmetic.
  task automatic model(input int unsigned o, input int unsigned aa, input int unsigned bb,
                       output logic [RW-1:0] r, output logic e, output int lat);
    int unsigned m;
    int unsigned v;
    m = 1 << W;
    v = 0;
    e = 1'b0;
    lat = 1;
    case (o)
      0: v = aa & bb;
      1: v = aa | bb;
      2: v = (m - 1) - aa;
      3: v = aa ^ bb;
      4: v = aa + bb;
      5: v = ((aa + m - bb) % m) + ((aa < bb) ? m : 0);
      6: begin v = aa * bb; lat = W + 1; end
      default: begin
`ifdef SEQ_ALU_DIV_EN
        if (bb == 0) begin
          v = aa * m + (m - 1);
          e = 1'b1;
        end else begin
          v = (aa % bb) * m + (aa / bb);
          lat = W + 1;
        end
`else
        v = 0;
        e = 1'b1;
`endif
      end
    endcase
    r = RW'(v);
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic [RW-1:0] r, input logic e, input int lat);
    exp_t x;
    int   n;
    bit   got;
    n = 0;
    got = 1'b0;
    in_valid = 1'b1;
    a = aa;
    b = bb;
    op = o;
    while (!got && n <= 100) begin
      @(negedge clk);
      if (in_ready) begin
        x.res = r;
        x.err = e;
        x.lat = lat;
        x.acc_cyc = cyc;
        sb.push_back(x);
        got = 1'b1;
      end
      n++;
    end
    if (!got) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (got) outstanding = 1'b1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    op = 3'($urandom);
  endtask

  task automatic issue_model(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
    logic [RW-1:0] r;
    logic          e;
    int            lat;
    model(o, aa, bb, r, e, lat);
    issue(o, aa, bb, r, e, lat);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("valid_timeout", out_valid, 1);
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("in_ready", in_ready, !outstanding);
        if (out_valid) begin
          if (sb.size() == 0) begin
            check("spurious_valid", out_valid, 0);
          end else begin
            e = sb[0];
            if (seen_cyc < 0) begin
              seen_cyc = cyc;
              check("latency", cyc - e.acc_cyc, e.lat);
            end
            check("result", result, e.res);
            check("err", err, e.err);
            if (out_ready) begin
              void'(sb.pop_front());
              seen_cyc = -1;
              @(posedge clk);
              #1;
              outstanding = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    logic [RW-1:0] div_r;
    logic          div_e;
    int            div_lat;

    ready_mode = 2;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    issue(3'd4, 8'd200, 8'd100, 16'h012C, 1'b0, 1);
    issue(3'd5, 8'd5,   8'd7,   16'h01FE, 1'b0, 1);
    issue(3'd2, 8'h0F,  8'hA5,  16'h00F0, 1'b0, 1);
    issue(3'd6, 8'd255, 8'd255, 16'hFE01, 1'b0, W + 1);
`ifdef SEQ_ALU_DIV_EN
    issue(3'd7, 8'd200, 8'd7,   16'h041C, 1'b0, W + 1);
    issue(3'd7, 8'd200, 8'd0,   16'hC8FF, 1'b1, 1);
`else
    issue(3'd7, 8'd200, 8'd7,   16'h0000, 1'b1, 1);
    issue(3'd7, 8'd200, 8'd0,   16'h0000, 1'b1, 1);
`endif
    issue(3'd0, 8'hF0,  8'h3C,  16'h0030, 1'b0, 1);
    issue(3'd1, 8'hF0,  8'h3C,  16'h00FC, 1'b0, 1);
    issue(3'd3, 8'hF0,  8'h3C,  16'h00CC, 1'b0, 1);
    drain();

    // Backpressure: result held while new operands wait at the input.
    ready_mode = 1;
    issue(3'd4, 8'd200, 8'd100, 16'h012C, 1'b0, 1);
    wait_valid();
    in_valid = 1'b1;
    a = 8'd5;
    b = 8'd7;
    op = 3'd5;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_result", result, 16'h012C);
    end
    ready_mode = 2;
    issue(3'd5, 8'd5, 8'd7, 16'h01FE, 1'b0, 1);
    drain();

    ready_mode = 0;
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      issue_model(3'($urandom), ra, rb);
    end
    ready_mode = 2;
    drain();

    // Asynchronous reset on the third BUSY cycle of a multiply.
    issue(3'd6, 8'd13, 8'd11, 16'h008F, 1'b0, W + 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    outstanding = 1'b0;
    seen_cyc = -1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_result", result, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(3'd6, 8'd13, 8'd11, 16'h008F, 1'b0, W + 1);
    model(7, 200, 7, div_r, div_e, div_lat);
    issue(3'd7, 8'd200, 8'd7, div_r, div_e, div_lat);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle arithmetic/logic unit: the clocked, width-generic successor to the team's 4-bit combinational calculator. It takes operand pairs through a valid/ready handshake, computes logic, add and subtract in one cycle and multiply/divide iteratively (shift-add / restoring), and holds each result until the consumer accepts it. It sits between the keypad/operand front end and the display formatter.

## Interface
- WIDTH, 8, operand width in bits (≥2); result width is 2*WIDTH
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  unit can accept; high only in IDLE
- a  in  WIDTH  operand A (unsigned)
- b  in  WIDTH  operand B (unsigned)
- op  in  3  000 AND, 001 OR, 010 NOT, 011 XOR, 100 ADD, 101 SUB, 110 MUL, 111 DIV
- out_valid  out  1  result held and valid
- out_ready  in  1  consumer accepts result
- result  out  2*WIDTH  result word, format per op below
- err  out  1  divide-by-zero or disabled op; qualified by out_valid

## Operation
- Operation is always A op B; a, b, op captured into internal registers on accept (in_valid && in_ready); later input changes ignored.
- FSM states: IDLE → (accept, op ≠ MUL/DIV, or DIV with b==0) → DONE; IDLE → (accept, MUL or DIV with b≠0) → BUSY; BUSY → (iteration counter reaches WIDTH-1) → DONE; DONE → (out_ready) → IDLE.
- in_ready = (state==IDLE); out_valid = (state==DONE). No back-to-back acceptance; new input is never taken in DONE or BUSY.
- Result formats (upper bits not listed are zero):
  - AND/OR/XOR: result[WIDTH-1:0] = a&b / a|b / a^b.
  - NOT: result[WIDTH-1:0] = ~a; b ignored.
  - ADD: result[WIDTH:0] = a+b (bit WIDTH is carry-out).
  - SUB: result[WIDTH-1:0] = (a−b) mod 2^WIDTH; result[WIDTH] = 1 iff a<b (borrow).
  - MUL: result = full 2*WIDTH unsigned product, one shift-add step per BUSY cycle.
  - DIV: result[WIDTH-1:0] = quotient, result[2*WIDTH-1:WIDTH] = remainder; restoring division, one quotient bit per BUSY cycle.
- Divide by zero: no iteration; quotient all ones, remainder = a, err=1.
- err=0 for every other op.
- result and err stable throughout DONE regardless of inputs.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, result=0, err=0, counter=0. Reset mid-BUSY or mid-DONE aborts the operation; the result is discarded.
- Single-cycle ops and DIV-by-zero: out_valid rises on the first clock edge after the accept edge (latency 1).
- MUL/DIV: WIDTH cycles in BUSY; out_valid rises WIDTH+1 edges after the accept edge (9 for WIDTH=8).
- Result handshake completes on the edge where out_valid && out_ready. in_ready is high the following cycle; minimum issue interval is latency+1 cycles.
- out_ready held low: DONE persists indefinitely, no data loss.
- Iteration counter width is $clog2(WIDTH); counter clears on accept.

## Configuration
- SEQ_ALU_DIV_EN defined: divider datapath compiled in, DIV behaves as above.
- SEQ_ALU_DIV_EN undefined: divider logic removed. DIV takes the single-cycle path to DONE with result=0 and err=1. All other ops are unchanged.

## Test plan
- WIDTH=8, ADD a=200 b=100 → out_valid 1 cycle after accept, result=0x012C, err=0.
- SUB a=5 b=7 → result=0x01FE (borrow set, low byte 0xFE); NOT a=0x0F → result=0x00F0.
- MUL a=255 b=255 → out_valid exactly 9 cycles after accept, result=0xFE01; in_ready low throughout.
- DIV a=200 b=7 → result=0x041C (q=28, r=4) after 9 cycles. DIV a=200 b=0 → result=0xC8FF, err=1, latency 1. With SEQ_ALU_DIV_EN undefined, DIV a=200 b=7 → result=0, err=1.
- Backpressure: hold out_ready=0 for 5 cycles after an ADD result, driving in_valid with new operands → result unchanged, in_ready=0, new op not taken. Release out_ready → IDLE next cycle, then the new op is accepted.
- Assert rst_n low on the 3rd BUSY cycle of MUL 13×11 → out_valid=0, in_ready=1 immediately. After release, MUL 13×11 → result=0x008F.
